// File: rtl/parity_frame_tx_pkg.sv
// Shared definitions for the parity frame transmitter: state encodings,
// frame length and the idle level of the serial line.
package parity_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int   FRAME_BITS = 7;
    localparam logic LINE_IDLE  = 1'b1;

endpackage

// File: rtl/gen_even.sv
// 4-bit even-parity generator: e makes the total count of ones in {a,b,c,d,e} even.
module gen_even (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e
);

    assign e = a ^ b ^ c ^ d;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, 4 data bits MSB first, parity bit, stop bit.
// The nibble and its parity are captured at the valid/ready handshake.
module parity_frame_tx
    import parity_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic       ODD_BIT   = (ODD_PARITY != 0);

    state_t     state_reg, state_next;
    logic [7:0] baud_reg, baud_next;
    logic [1:0] bit_reg, bit_next;
    logic [3:0] shift_reg, shift_next;
    logic       parity_reg, parity_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       tx_reg, tx_next;
    logic       busy_reg;
    logic       par_even;
    logic       last_baud;

    gen_even u_gen_even (
        .a (in_data[3]),
        .b (in_data[2]),
        .c (in_data[1]),
        .d (in_data[0]),
        .e (par_even)
    );

    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        cnt_next    = cnt_reg;
        last_baud   = (baud_reg == BAUD_LAST);

        case (state_reg)
            ST_IDLE: begin
                // in_data is only looked at on a real transfer, so X elsewhere never reaches tx.
                if (in_valid) begin
                    state_next  = ST_START;
                    baud_next   = '0;
                    bit_next    = '0;
                    shift_next  = in_data;
                    parity_next = par_even ^ ODD_BIT;
                end
            end
            ST_START: begin
                if (last_baud) begin
                    state_next = ST_DATA;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + 8'd1;
                end
            end
            ST_DATA: begin
                if (last_baud) begin
                    baud_next = '0;
                    if (bit_reg == 2'd3) begin
                        state_next = ST_PARITY;
                    end else begin
                        bit_next   = bit_reg + 2'd1;
                        shift_next = {shift_reg[2:0], 1'b0};
                    end
                end else begin
                    baud_next = baud_reg + 8'd1;
                end
            end
            ST_PARITY: begin
                if (last_baud) begin
                    state_next = ST_STOP;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + 8'd1;
                end
            end
            ST_STOP: begin
                if (last_baud) begin
                    state_next = ST_IDLE;
                    baud_next  = '0;
                    cnt_next   = cnt_reg + 8'd1;
                end else begin
                    baud_next = baud_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
            end
        endcase

        // tx is registered, so it is derived from where the FSM goes next.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[3];
            ST_PARITY: tx_next = parity_next;
            default:   tx_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            cnt_reg    <= '0;
            tx_reg     <= LINE_IDLE;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            cnt_reg    <= cnt_next;
            tx_reg     <= tx_next;
            busy_reg   <= (state_next != ST_IDLE);
        end
    end

    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign done      = (state_reg == ST_STOP) && (baud_reg == BAUD_LAST);
    assign tx        = tx_reg;
    assign busy      = busy_reg;
    assign frame_cnt = cnt_reg;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx: three instances (even/4, odd/4, even/1);
// a per-instance monitor rebuilds each frame from tx and checks it on done.
module tb_parity_frame_tx;
    import parity_frame_tx_pkg::*;

    localparam int NDUT = 3;
    localparam int CPB_T [NDUT] = '{4, 4, 1};
    localparam int ODD_T [NDUT] = '{0, 1, 0};

    typedef struct {
        logic [6:0] frame;
        logic [7:0] cnt;
        int         gap;
    } exp_t;

    logic       clk;
    logic       rst      [NDUT];
    logic       in_valid [NDUT];
    logic       in_ready [NDUT];
    logic [3:0] in_data  [NDUT];
    logic       tx       [NDUT];
    logic       busy     [NDUT];
    logic       done     [NDUT];
    logic [7:0] frame_cnt[NDUT];

    exp_t exp_q [NDUT][$];
    int   n_vec;
    int   n_bad;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        parity_frame_tx #(
            .CLKS_PER_BIT (CPB_T[gi]),
            .ODD_PARITY   (ODD_T[gi])
        ) u_dut (
            .clk       (clk),
            .rst       (rst[gi]),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data[gi]),
            .tx        (tx[gi]),
            .busy      (busy[gi]),
            .done      (done[gi]),
            .frame_cnt (frame_cnt[gi])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitors: collect tx while busy, score the frame when done is seen.
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_mon
        initial begin
            logic       smp[$];
            int         acc_cyc, last_acc, gap_seen, glitch, cpb;
            bit         cnt_pending;
            logic [7:0] cnt_want;
            logic [6:0] got;
            exp_t       e;
            acc_cyc = 0; last_acc = -100000; gap_seen = 0;
            cnt_pending = 0; cnt_want = '0;
            cpb = CPB_T[gi];
            forever begin
                @(negedge clk);
                if (cnt_pending) begin
                    check($sformatf("d%0d_frame_cnt", gi), 32'(frame_cnt[gi]), 32'(cnt_want));
                    check($sformatf("d%0d_ready_after", gi), 32'(in_ready[gi]), 32'd1);
                    cnt_pending = 0;
                end
                if (busy[gi] === 1'b1) smp.push_back(tx[gi]);
                if (done[gi] === 1'b1) begin
                    if (exp_q[gi].size() == 0) begin
                        check($sformatf("d%0d_unexpected_done", gi), 32'd1, 32'd0);
                    end else begin
                        e = exp_q[gi].pop_front();
                        got = '0;
                        glitch = 0;
                        check($sformatf("d%0d_frame_len", gi), 32'(smp.size()), 32'(FRAME_BITS * cpb));
                        if (smp.size() == FRAME_BITS * cpb) begin
                            for (int s = 0; s < FRAME_BITS; s++) begin
                                got[6 - s] = smp[s * cpb];
                                for (int j = 1; j < cpb; j++)
                                    if (smp[s * cpb + j] !== smp[s * cpb]) glitch++;
                            end
                        end
                        check($sformatf("d%0d_frame_bits", gi), 32'(got), 32'(e.frame));
                        check($sformatf("d%0d_slot_stable", gi), 32'(glitch), 32'd0);
                        check($sformatf("d%0d_done_time", gi), 32'(cyc - acc_cyc), 32'(FRAME_BITS * cpb - 1));
                        if (e.gap != 0)
                            check($sformatf("d%0d_accept_gap", gi), 32'(gap_seen), 32'(e.gap));
                        cnt_pending = 1;
                        cnt_want = e.cnt;
                    end
                    smp.delete();
                end
                if (in_valid[gi] === 1'b1 && in_ready[gi] === 1'b1) begin
                    acc_cyc  = cyc + 1;
                    gap_seen = acc_cyc - last_acc;
                    last_acc = acc_cyc;
                    smp.delete();
                end
            end
        end
    end

    task automatic push_exp(input int k, input logic [6:0] frame, input logic [7:0] cnt, input int gap);
        exp_t e;
        e.frame = frame;
        e.cnt   = cnt;
        e.gap   = gap;
        exp_q[k].push_back(e);
    endtask

    // Returns at a negedge with in_ready high, so the transfer lands on the next posedge.
    task automatic wait_ready(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready[k] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("d%0d_ready_timeout", k), 32'(in_ready[k]), 32'd1);
    endtask

    task automatic send(input int k, input logic [3:0] d, input logic [6:0] frame,
                        input logic [7:0] cnt);
        push_exp(k, frame, cnt, 0);
        @(posedge clk); #1;
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        wait_ready(k);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_data[k]  = ~d;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((exp_q[k].size() != 0 || busy[k] !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("d%0d_drain_timeout", k), 32'(exp_q[k].size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [15:0] par_tab;
        logic [3:0]  nib;
        n_vec = 0;
        n_bad = 0;
        par_tab = 16'h6996;
        for (int k = 0; k < NDUT; k++) begin
            rst[k]      = 1'b1;
            in_valid[k] = 1'b0;
            in_data[k]  = 4'h0;
        end

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            check("rst_tx",       32'(tx[0]),        32'd1);
            check("rst_busy",     32'(busy[0]),      32'd0);
            check("rst_done",     32'(done[0]),      32'd0);
            check("rst_frame_cnt",32'(frame_cnt[0]), 32'd0);
            check("rst_in_ready", 32'(in_ready[0]),  32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready[0]), 32'd1);

        // 1011: three ones, even parity bit 1.
        send(0, 4'b1011, 7'b0_1011_1_1, 8'd1);
        drain(0);

        // Back-to-back with in_valid held: 0110 then 0000.
        push_exp(0, 7'b0_0110_0_1, 8'd2, 0);
        push_exp(0, 7'b0_0000_0_1, 8'd3, 29);
        @(posedge clk); #1;
        in_data[0]  = 4'b0110;
        in_valid[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1;
        in_data[0] = 4'b0000;
        wait_ready(0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        in_data[0]  = 4'hF;
        drain(0);

        // Odd parity instance: 1111 gives parity 1.
        send(1, 4'b1111, 7'b0_1111_1_1, 8'd1);
        drain(1);

        // Abort in the DATA bit[2] slot of a 1010 frame.
        @(posedge clk); #1;
        in_data[0]  = 4'b1010;
        in_valid[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_pre_tx", 32'(tx[0]), 32'd0);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check("abort_tx",        32'(tx[0]),        32'd1);
        check("abort_busy",      32'(busy[0]),      32'd0);
        check("abort_done",      32'(done[0]),      32'd0);
        check("abort_frame_cnt", 32'(frame_cnt[0]), 32'd0);
        check("abort_in_ready",  32'(in_ready[0]),  32'd0);
        rst[0] = 1'b0;
        send(0, 4'b1000, 7'b0_1000_1_1, 8'd1);
        drain(0);

        // One-cycle bits, 256 frames; counter wraps to 0 on the last.
        for (int i = 0; i < 256; i++) begin
            nib = 4'(i);
            send(2, nib, {1'b0, nib, par_tab[nib], 1'b1}, 8'(i + 1));
        end
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
